// File: rtl/vga_cell_tracker.sv
// Watches a TinyVGA PMOD stream, rebuilds the pixel position from the sync edges and
// reports the single 32x32 cell that differs from the background once per frame.
module vga_cell_tracker #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_ACT_START = 144,
   parameter int V_ACT_START = 35
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] vga_in,
   output logic [4:0] cell_x,
   output logic [3:0] cell_y,
   output logic [5:0] cell_color,
   output logic [5:0] bg_color,
   output logic       cell_valid,
   output logic       frame_done,
   output logic       locked
);

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT_LO = 10'(H_ACT_START);
   localparam logic [9:0]  H_ACT_HI = 10'(H_ACT_START + 640);
   localparam logic [9:0]  V_ACT_LO = 10'(V_ACT_START);
   localparam logic [9:0]  V_ACT_HI = 10'(V_ACT_START + 480);
   localparam logic [18:0] CNT_CELL = 19'd1024;
   localparam logic [18:0] CNT_INV  = 19'd306176;
   localparam logic [7:0]  VGA_IDLE = 8'h88;

   typedef enum logic {
      S_WAIT_VS,
      S_TRACK
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  vga1_q, vga2_q;
   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [5:0]  ref_q, ref_d;
   logic [18:0] diff_cnt_q, diff_cnt_d;
   logic        first_seen_q, first_seen_d;
   logic [4:0]  fd_x_q, fd_x_d;
   logic [3:0]  fd_y_q, fd_y_d;
   logic [5:0]  fd_col_q, fd_col_d;
   logic        err_q, err_d;
   logic [4:0]  cell_x_q, cell_x_d;
   logic [3:0]  cell_y_q, cell_y_d;
   logic [5:0]  cell_col_q, cell_col_d;
   logic [5:0]  bg_col_q, bg_col_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic        locked_q, locked_d;

   logic        hs_fall, vs_fall;
   logic [5:0]  pix;
   logic        active, is_origin, differs, frame_err;
   logic [9:0]  x, y;

   // The second copy is one clock behind the first, so it lines up with h_cnt.
   assign hs_fall = vga2_q[7] & ~vga1_q[7];
   assign vs_fall = vga2_q[3] & ~vga1_q[3];
   assign pix     = {vga2_q[0], vga2_q[4], vga2_q[1], vga2_q[5], vga2_q[2], vga2_q[6]};

   assign active    = (h_cnt_q >= H_ACT_LO) && (h_cnt_q < H_ACT_HI) &&
                      (v_cnt_q >= V_ACT_LO) && (v_cnt_q < V_ACT_HI);
   assign x         = h_cnt_q - H_ACT_LO;
   assign y         = v_cnt_q - V_ACT_LO;
   assign is_origin = active && (x == '0) && (y == '0);
   assign differs   = active && !is_origin && (pix != ref_q);
   assign frame_err = err_q || (hs_fall && (h_cnt_q != H_LAST)) ||
                      (vs_fall && (v_cnt_q != V_LAST));

   always_comb begin
      state_d      = state_q;
      h_cnt_d      = hs_fall ? '0 : ((h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 10'd1);
      v_cnt_d      = v_cnt_q;
      ref_d        = is_origin ? pix : ref_q;
      diff_cnt_d   = diff_cnt_q;
      first_seen_d = first_seen_q;
      fd_x_d       = fd_x_q;
      fd_y_d       = fd_y_q;
      fd_col_d     = fd_col_q;
      err_d        = frame_err;
      cell_x_d     = cell_x_q;
      cell_y_d     = cell_y_q;
      cell_col_d   = cell_col_q;
      bg_col_d     = bg_col_q;
      valid_d      = valid_q;
      done_d       = 1'b0;
      locked_d     = locked_q;

      if (vs_fall)
         v_cnt_d = '0;
      else if (hs_fall && (v_cnt_q != '1))
         v_cnt_d = v_cnt_q + 10'd1;

      if (differs) begin
         if (diff_cnt_q != '1)
            diff_cnt_d = diff_cnt_q + 19'd1;
         if (!first_seen_q) begin
            first_seen_d = 1'b1;
            fd_x_d       = x[9:5];
            fd_y_d       = y[8:5];
            fd_col_d     = pix;
         end
      end

      if (vs_fall) begin
         state_d      = S_TRACK;
         diff_cnt_d   = '0;
         first_seen_d = 1'b0;
         err_d        = 1'b0;
         // The first fall after reset only marks a frame boundary; nothing is published.
         if (state_q == S_TRACK) begin
            done_d   = 1'b1;
            locked_d = !frame_err;
            valid_d  = 1'b0;
            if (!frame_err && (diff_cnt_q == CNT_CELL)) begin
               cell_x_d   = fd_x_q;
               cell_y_d   = fd_y_q;
               cell_col_d = fd_col_q;
               bg_col_d   = ref_q;
               valid_d    = 1'b1;
            end else if (!frame_err && (diff_cnt_q == CNT_INV)) begin
               cell_x_d   = '0;
               cell_y_d   = '0;
               cell_col_d = ref_q;
               bg_col_d   = fd_col_q;
               valid_d    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_WAIT_VS;
         vga1_q       <= VGA_IDLE;
         vga2_q       <= VGA_IDLE;
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         ref_q        <= '0;
         diff_cnt_q   <= '0;
         first_seen_q <= 1'b0;
         fd_x_q       <= '0;
         fd_y_q       <= '0;
         fd_col_q     <= '0;
         err_q        <= 1'b0;
         cell_x_q     <= '0;
         cell_y_q     <= '0;
         cell_col_q   <= '0;
         bg_col_q     <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         vga1_q       <= vga_in;
         vga2_q       <= vga1_q;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         ref_q        <= ref_d;
         diff_cnt_q   <= diff_cnt_d;
         first_seen_q <= first_seen_d;
         fd_x_q       <= fd_x_d;
         fd_y_q       <= fd_y_d;
         fd_col_q     <= fd_col_d;
         err_q        <= err_d;
         cell_x_q     <= cell_x_d;
         cell_y_q     <= cell_y_d;
         cell_col_q   <= cell_col_d;
         bg_col_q     <= bg_col_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         locked_q     <= locked_d;
      end
   end

   assign cell_x     = cell_x_q;
   assign cell_y     = cell_y_q;
   assign cell_color = cell_col_q;
   assign bg_color   = bg_col_q;
   assign cell_valid = valid_q;
   assign frame_done = done_q;
   assign locked     = locked_q;

endmodule

// File: doc/vga_cell_tracker.md
VGA_CELL_TRACKER -- requirements
Module: vga_cell_tracker

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 SHALL have parameter H_ACT_START, default 144, meaning h_cnt of the first active pixel (sync 96 + back porch 48).
REQ-004 SHALL have parameter V_ACT_START, default 35, meaning v_cnt of the first active line (sync 2 + back porch 33).
REQ-005 SHALL have port clk  input  1  pixel clock, the one clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port vga_in  input  8  TinyVGA PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}; syncs active-low.
REQ-008 SHALL have port cell_x  output  5  detected cell column (pixel x[9:5]).
REQ-009 SHALL have port cell_y  output  4  detected cell row (pixel y[8:5]).
REQ-010 SHALL have port cell_color  output  6  cell colour {R1,R0,G1,G0,B1,B0}.
REQ-011 SHALL have port bg_color  output  6  background colour, same packing.
REQ-012 SHALL have port cell_valid  output  1  last published frame held exactly one 32x32 cell.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when results update.
REQ-014 SHALL have port locked  output  1  last published frame had correct timing.

Function
REQ-015 SHALL register vga_in once, then detect falling edges of hsync and vsync against a second registered copy; edge-to-counter latency is 2 clocks.
REQ-016 SHALL clear h_cnt (10 bit) to 0 on each hsync falling edge; otherwise it increments, saturating at 1023.
REQ-017 SHALL increment v_cnt (10 bit) on each hsync falling edge, saturating at 1023; a vsync falling edge clears v_cnt to 0; when both edges occur in the same cycle, the clear wins.
REQ-018 SHALL treat a pixel as active when H_ACT_START <= h_cnt < H_ACT_START+640 and V_ACT_START <= v_cnt < V_ACT_START+480; x = h_cnt-H_ACT_START, y = v_cnt-V_ACT_START.
REQ-019 SHALL capture the colour of active pixel (0,0) as the frame's reference colour.
REQ-020 SHALL count active pixels whose colour differs from the reference in a 19-bit counter saturating at 524287, and SHALL latch x[9:5], y[8:5] and the colour of the first differing pixel.
REQ-021 SHALL flag a timing error for the frame when an hsync falling edge arrives with h_cnt != H_TOTAL-1.
REQ-022 SHALL flag a timing error for the frame when a vsync falling edge arrives with v_cnt != V_TOTAL-1.
REQ-023 SHALL publish results on each vsync falling edge (except the first after reset) and pulse frame_done for exactly that cycle.
REQ-024 SHALL publish diff count == 1024 as cell = first-diff position, cell_color = first-diff colour, bg_color = reference, cell_valid=1.
REQ-025 SHALL publish diff count == 306176 as cell = (0,0), cell_color = reference, bg_color = first-diff colour, cell_valid=1.
REQ-026 SHALL, for any other diff count, hold cell_x/cell_y/cell_color/bg_color at their previous values and publish cell_valid=0.
REQ-027 SHALL set locked = no timing error flagged in the published frame; a frame with a timing error also forces cell_valid=0.
REQ-028 SHALL clear the per-frame accumulators (diff count, first-diff capture, error flag) in the same cycle as publication.
REQ-029 SHALL keep outputs stable between frame_done pulses.

Reset
REQ-030 SHALL make all outputs 0 while reset is high, and SHALL set h_cnt=0, v_cnt=0, accumulators cleared, and sync history registers to 1 (idle) so that no false edge follows reset.
REQ-031 SHALL treat the first vsync falling edge after reset as arming only: no frame_done, outputs unchanged.
REQ-032 SHALL let a reset asserted mid-frame abandon that frame with no pulse.

Verification
REQ-033 SHALL pass: reset, 3 legal frames with a 32x32 cell of 6'b11_00_11 at x=256..287, y=128..159 on 6'b00_11_00 -> 2 frame_done pulses; cell_x=8, cell_y=4, cell_color=110011, bg_color=001100, cell_valid=1, locked=1.
REQ-034 SHALL pass: cell at (0,0) -> cell_x=0, cell_y=0, colours correctly assigned, cell_valid=1.
REQ-035 SHALL pass: cell at x=608..639, y=448..479 -> cell_x=19, cell_y=14, cell_valid=1.
REQ-036 SHALL pass: one line of 799 clocks in a frame -> that frame's locked=0, cell_valid=0; the next legal frame restores both to 1.
REQ-037 SHALL pass: uniform colour frame (diff count 0) -> cell_valid=0, locked=1, cell_x/cell_y unchanged.
REQ-038 SHALL pass: reset pulsed mid-frame -> outputs 0, no frame_done until the second vsync fall after release.
